// File: rtl/elastic_pipe_reg_if.sv
// Handshake bundle for one elastic pipeline boundary: upstream valid/ready/data,
// downstream valid/ready/data and the occupancy count.
interface elastic_pipe_reg_if #(
  parameter int WIDTH = 32
);
  logic             In_Valid;
  logic             In_Ready;
  logic [WIDTH-1:0] In_Data;
  logic             Out_Valid;
  logic             Out_Ready;
  logic [WIDTH-1:0] Out_Data;
  logic [1:0]       Occupancy;

  // The pipeline stage itself.
  modport slave (
    input  In_Valid, In_Data, Out_Ready,
    output In_Ready, Out_Valid, Out_Data, Occupancy
  );

  // The producer/consumer side surrounding the stage.
  modport master (
    output In_Valid, In_Data, Out_Ready,
    input  In_Ready, Out_Valid, Out_Data, Occupancy
  );
endinterface

// File: rtl/elastic_pipe_reg.sv
// Elastic pipeline register: main register plus one skid entry, full throughput,
// In_Ready decoded from state only, flush squashes everything held.
module elastic_pipe_reg #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Flush,
  elastic_pipe_reg_if.slave   pipe
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_fire;
  logic             out_fire;

  assign in_fire  = pipe.In_Valid  && pipe.In_Ready;
  assign out_fire = pipe.Out_Valid && pipe.Out_Ready;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (Flush) begin
      // Beats accepted this cycle are dropped; a concurrent out_fire still counts downstream.
      state_d = EMPTY;
      main_d  = RESET_VAL;
      skid_d  = RESET_VAL;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            main_d  = pipe.In_Data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = pipe.In_Data;
          end else if (in_fire) begin
            state_d = FULL;
            skid_d  = pipe.In_Data;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  assign pipe.Out_Valid = (state_q != EMPTY);
  assign pipe.In_Ready  = (state_q != FULL) && !Rst;
  assign pipe.Occupancy = state_q;
  assign pipe.Out_Data  = main_q;

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Bench for elastic_pipe_reg: 8- and 64-bit instances driven in lockstep and checked
// every cycle against a queue-based scoreboard.
module tb_elastic_pipe_reg;

  localparam logic [7:0]  RV8  = 8'hA5;
  localparam logic [63:0] RV64 = 64'h0123_4567_89AB_CDEF;

  logic Clk = 1'b0;
  logic Rst;
  logic Flush;

  always #5 Clk = ~Clk;

  elastic_pipe_reg_if #(.WIDTH(8))  pif8 ();
  elastic_pipe_reg_if #(.WIDTH(64)) pif64 ();

  elastic_pipe_reg #(.WIDTH(8), .RESET_VAL(RV8)) dut8 (
    .Clk  (Clk),
    .Rst  (Rst),
    .Flush(Flush),
    .pipe (pif8)
  );

  elastic_pipe_reg #(.WIDTH(64), .RESET_VAL(RV64)) dut64 (
    .Clk  (Clk),
    .Rst  (Rst),
    .Flush(Flush),
    .pipe (pif64)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] sb_q[$];
  logic [63:0] stale;
  logic        idle_is_reset = 1'b1;
  logic        checking      = 1'b0;
  logic        ready_probe   = 1'b0;
  int          n_out         = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic ordy,
                       input logic fl, input logic rs);
    pif8.In_Valid   = v;
    pif64.In_Valid  = v;
    pif8.In_Data    = d[7:0];
    pif64.In_Data   = d;
    pif8.Out_Ready  = ordy;
    pif64.Out_Ready = ordy;
    Flush           = fl;
    Rst             = rs;
  endtask

  // One clock: check outputs at negedge against the model, then advance the model at posedge.
  task automatic step();
    logic        exp_ready, exp_valid, in_fire, out_fire, r8, r64;
    logic [63:0] exp_head, popped;
    @(negedge Clk);
    exp_ready = !Rst && (sb_q.size() < 2);
    exp_valid = (sb_q.size() > 0);
    if (exp_valid)          exp_head = sb_q[0];
    else if (idle_is_reset) exp_head = RV64;
    else                    exp_head = stale;
    if (checking) begin
      chk("in_ready8",   {63'd0, pif8.In_Ready},   {63'd0, exp_ready});
      chk("in_ready64",  {63'd0, pif64.In_Ready},  {63'd0, exp_ready});
      chk("out_valid8",  {63'd0, pif8.Out_Valid},  {63'd0, exp_valid});
      chk("out_valid64", {63'd0, pif64.Out_Valid}, {63'd0, exp_valid});
      chk("occ8",        {62'd0, pif8.Occupancy},  64'(sb_q.size()));
      chk("occ64",       {62'd0, pif64.Occupancy}, 64'(sb_q.size()));
      if (!exp_valid && idle_is_reset)
        chk("out_data8", {56'd0, pif8.Out_Data}, {56'd0, RV8});
      else
        chk("out_data8", {56'd0, pif8.Out_Data}, {56'd0, exp_head[7:0]});
      chk("out_data64", pif64.Out_Data, exp_head);
      if (ready_probe) begin
        r8  = pif8.In_Ready;
        r64 = pif64.In_Ready;
        pif8.Out_Ready  = !pif8.Out_Ready;
        pif64.Out_Ready = !pif64.Out_Ready;
        #1;
        chk("ready_comb8",  {63'd0, pif8.In_Ready},  {63'd0, r8});
        chk("ready_comb64", {63'd0, pif64.In_Ready}, {63'd0, r64});
        pif8.Out_Ready  = !pif8.Out_Ready;
        pif64.Out_Ready = !pif64.Out_Ready;
      end
    end
    in_fire  = pif64.In_Valid && exp_ready;
    out_fire = exp_valid && pif64.Out_Ready;
    @(posedge Clk);
    if (Rst || Flush) begin
      if (!Rst && out_fire) n_out++;
      sb_q.delete();
      idle_is_reset = 1'b1;
    end else begin
      if (out_fire) begin
        popped        = sb_q.pop_front();
        stale         = popped;
        idle_is_reset = 1'b0;
        n_out++;
      end
      if (in_fire) sb_q.push_back(pif64.In_Data);
    end
    #1;
  endtask

  initial begin
    drive(1'b1, 64'h0, 1'b0, 1'b0, 1'b1);
    step();
    checking = 1'b1;
    step();                                   // reset held, In_Valid=1
    // Streaming at full throughput.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 64'(i), 1'b1, 1'b0, 1'b0);
      step();
    end
    repeat (2) begin drive(1'b0, 64'h0, 1'b1, 1'b0, 1'b0); step(); end
    // Backpressure fills the skid entry, then drains in order.
    drive(1'b1, 64'hA, 1'b0, 1'b0, 1'b0);  step();
    drive(1'b1, 64'hB, 1'b0, 1'b0, 1'b0);  step();
    drive(1'b1, 64'hEE, 1'b0, 1'b0, 1'b0); step();
    repeat (3) begin drive(1'b0, 64'h0, 1'b1, 1'b0, 1'b0); step(); end
    // Flush while full with a concurrent push.
    drive(1'b1, 64'hA, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 64'hB, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 64'hC, 1'b0, 1'b1, 1'b0); step();
    repeat (2) begin drive(1'b0, 64'h0, 1'b1, 1'b0, 1'b0); step(); end
    // Flush in ONE with a concurrent drain and push.
    drive(1'b1, 64'h7, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 64'h8, 1'b1, 1'b1, 1'b0); step();
    drive(1'b0, 64'h0, 1'b1, 1'b0, 1'b0); step();
    // Reset mid-stream while full.
    drive(1'b1, 64'h1, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 64'h2, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 64'h3, 1'b0, 1'b0, 1'b1); step();
    drive(1'b1, 64'h5, 1'b1, 1'b0, 1'b0); step();
    repeat (2) begin drive(1'b0, 64'h0, 1'b1, 1'b0, 1'b0); step(); end
    // Random traffic with occasional flush/reset.
    ready_probe = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      drive(1'($urandom_range(0, 1)), {$urandom(), $urandom()},
            1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0),
            ($urandom_range(0, 255) == 0));
      step();
    end
    ready_probe = 1'b0;
    repeat (3) begin drive(1'b0, 64'h0, 1'b1, 1'b0, 1'b0); step(); end
    chk("drained", 64'(sb_q.size()), 64'd0);
    $display("beats delivered: %0d", n_out);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
